// File: rtl/aes_uart_tx_sequencer_if.sv
// Block handshake and UART byte-transaction bundle for aes_uart_tx_sequencer.
// master: the sequencer; slave: the AES/UART side that drives it.
interface aes_uart_tx_sequencer_if #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned BLOCK_BYTES = 16
);
   logic                                blk_valid;
   logic                                blk_ready;
   logic [BLOCK_BYTES*DATA_WIDTH-1:0]   blk_data;
   logic                                tx_drive;
   logic [DATA_WIDTH-1:0]               tx_byte_in;
   logic                                tx_active;
   logic                                tx_done;
   logic                                busy;
   logic                                blk_sent;
   logic                                timeout_err;

   modport master (
      input  blk_valid, blk_data, tx_active, tx_done,
      output blk_ready, tx_drive, tx_byte_in, busy, blk_sent, timeout_err
   );

   modport slave (
      output blk_valid, blk_data, tx_active, tx_done,
      input  blk_ready, tx_drive, tx_byte_in, busy, blk_sent, timeout_err
   );
endinterface

// File: rtl/aes_uart_tx_sequencer.sv
// Sends one AES ciphertext block, MSB byte first, through a byte-wide UART,
// with an optional header byte and a per-byte watchdog.
module aes_uart_tx_sequencer #(
   parameter int unsigned           DATA_WIDTH     = 8,
   parameter int unsigned           BLOCK_BYTES    = 16,
   parameter bit                    SEND_HEADER    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] HEADER_BYTE    = 8'hA5,
   parameter int unsigned           TIMEOUT_CYCLES = 8192
) (
   input  logic                     clk,
   input  logic                     reset_n,
   aes_uart_tx_sequencer_if.master  bus
);
   localparam int unsigned BLK_W = BLOCK_BYTES * DATA_WIDTH;
   localparam int unsigned N     = BLOCK_BYTES + (SEND_HEADER ? 1 : 0);
   localparam int unsigned CNT_W = $clog2(N + 1);
   localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N - 1);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

   state_t                state, next_state;
   logic [BLK_W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]      byte_cnt, byte_cnt_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
   logic                  blk_ready_q, tx_drive_q, busy_q, blk_sent_q, timeout_err_q;
   logic                  blk_ready_d, tx_drive_d, busy_d, blk_sent_d, timeout_err_d;
   logic                  accept, byte_done, wd_expired;

   assign accept     = (state == IDLE) && bus.blk_valid && blk_ready_q;
   assign byte_done  = (state == WAIT_DONE) && bus.tx_done;
   assign wd_expired = (state == WAIT_DONE) && !bus.tx_done && (wd_q == WD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         shift_q       <= '0;
         byte_cnt      <= '0;
         wd_q          <= '0;
         tx_byte_q     <= '0;
         blk_ready_q   <= 1'b0;
         tx_drive_q    <= 1'b0;
         busy_q        <= 1'b0;
         blk_sent_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state         <= next_state;
         shift_q       <= shift_d;
         byte_cnt      <= byte_cnt_d;
         wd_q          <= wd_d;
         tx_byte_q     <= tx_byte_d;
         blk_ready_q   <= blk_ready_d;
         tx_drive_q    <= tx_drive_d;
         busy_q        <= busy_d;
         blk_sent_q    <= blk_sent_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (accept) next_state = ISSUE;
         ISSUE:     next_state = WAIT_DONE;
         WAIT_DONE: begin
            if (bus.tx_done)          next_state = (byte_cnt == LAST_BYTE) ? FINISH : ISSUE;
            else if (wd_q == WD_LAST) next_state = IDLE;
         end
         FINISH:    next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Watchdog is zero during ISSUE and counts that cycle, so expiry lands
   // exactly TIMEOUT_CYCLES clocks after tx_drive; it saturates, never wraps.
   always_comb begin
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt;
      wd_d       = wd_q;
      if (accept) begin
         shift_d    = bus.blk_data;
         byte_cnt_d = '0;
      end else if (byte_done) begin
         byte_cnt_d = byte_cnt + CNT_W'(1);
         if (!(SEND_HEADER && (byte_cnt == '0)))
            shift_d = shift_q << DATA_WIDTH;
      end
      if (next_state == ISSUE)
         wd_d = '0;
      else if (((state == ISSUE) || (state == WAIT_DONE)) && (wd_q != WD_LAST))
         wd_d = wd_q + WD_W'(1);
   end

   always_comb begin
      blk_ready_d   = (next_state == IDLE);
      busy_d        = (next_state != IDLE);
      tx_drive_d    = (next_state == ISSUE);
      blk_sent_d    = (next_state == FINISH);
      timeout_err_d = wd_expired;
      tx_byte_d     = tx_byte_q;
      if (next_state == ISSUE)
         tx_byte_d = (SEND_HEADER && (byte_cnt_d == '0)) ? HEADER_BYTE
                                                        : shift_d[BLK_W-1 -: DATA_WIDTH];
   end

   assign bus.blk_ready   = blk_ready_q;
   assign bus.tx_drive    = tx_drive_q;
   assign bus.tx_byte_in  = tx_byte_q;
   assign bus.busy        = busy_q;
   assign bus.blk_sent    = blk_sent_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_aes_uart_tx_sequencer.sv
// Bench for aes_uart_tx_sequencer: header and header-less instances share one
// UART model; expected bytes are queued at stimulus time and compared per tx_drive.
`timescale 1ns/1ps
module tb_aes_uart_tx_sequencer;
   localparam int unsigned DW       = 8;
   localparam int unsigned BB       = 16;
   localparam int unsigned TO       = 64;
   localparam int          UART_LAT = 12;
   localparam int          BOUND    = 3000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   aes_uart_tx_sequencer_if #(.DATA_WIDTH(DW), .BLOCK_BYTES(BB)) ifa ();
   aes_uart_tx_sequencer_if #(.DATA_WIDTH(DW), .BLOCK_BYTES(BB)) ifb ();

   aes_uart_tx_sequencer #(
      .DATA_WIDTH(DW), .BLOCK_BYTES(BB), .SEND_HEADER(1'b1),
      .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut_hdr (.clk(clk), .reset_n(reset_n), .bus(ifa.master));

   aes_uart_tx_sequencer #(
      .DATA_WIDTH(DW), .BLOCK_BYTES(BB), .SEND_HEADER(1'b0),
      .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut_nohdr (.clk(clk), .reset_n(reset_n), .bus(ifb.master));

   logic         sel = 1'b0;
   logic         blk_valid = 1'b0;
   logic [127:0] blk_data = '0;
   logic         model_done = 1'b0;
   logic         inj_done = 1'b0;
   int           uart_cnt = 0;

   assign ifa.blk_valid = blk_valid & ~sel;
   assign ifb.blk_valid = blk_valid & sel;
   assign ifa.blk_data  = blk_data;
   assign ifb.blk_data  = blk_data;
   assign ifa.tx_done   = ~sel & (model_done | inj_done);
   assign ifb.tx_done   = sel & (model_done | inj_done);
   assign ifa.tx_active = ~sel & (uart_cnt != 0);
   assign ifb.tx_active = sel & (uart_cnt != 0);

   logic       mon_ready, mon_drive, mon_busy, mon_sent, mon_terr;
   logic [7:0] mon_byte;
   assign mon_ready = sel ? ifb.blk_ready   : ifa.blk_ready;
   assign mon_drive = sel ? ifb.tx_drive    : ifa.tx_drive;
   assign mon_busy  = sel ? ifb.busy        : ifa.busy;
   assign mon_sent  = sel ? ifb.blk_sent    : ifa.blk_sent;
   assign mon_terr  = sel ? ifb.timeout_err : ifa.timeout_err;
   assign mon_byte  = sel ? ifb.tx_byte_in  : ifa.tx_byte_in;

   int checks = 0, errors = 0;
   int cyc = 0, drv_cnt = 0, mute_idx = -1, sent_cnt = 0, terr_cnt = 0;
   int first_drive_cyc = -1, last_drive_cyc = 0, last_done_cyc = 0;
   int last_sent_cyc = 0, last_terr_cyc = 0;
   bit stretch = 1'b0, stretch_pend = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] B2 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

   // UART model (tx_done UART_LAT clocks after tx_drive) and scoreboard compare
   always @(negedge clk) begin
      cyc++;
      model_done = stretch_pend;
      stretch_pend = 1'b0;
      if (uart_cnt > 0) begin
         uart_cnt--;
         if (uart_cnt == 0) begin
            model_done = 1'b1;
            last_done_cyc = cyc;
            stretch_pend = stretch;
         end
      end
      if (mon_drive) begin
         if (first_drive_cyc < 0) first_drive_cyc = cyc;
         last_drive_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_order: unexpected tx_drive with byte %h, none expected", mon_byte);
         end else begin
            exp_b = exp_q.pop_front();
            if (mon_byte !== exp_b) begin
               errors++;
               $display("FAIL byte_order: byte %0d got %h expected %h", drv_cnt, mon_byte, exp_b);
            end
         end
         if (drv_cnt != mute_idx) uart_cnt = UART_LAT;
         drv_cnt++;
      end
      if (mon_sent) begin sent_cnt++; last_sent_cyc = cyc; end
      if (mon_terr) begin terr_cnt++; last_terr_cyc = cyc; end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_block(input logic [127:0] data, input bit hdr);
      if (hdr) exp_q.push_back(8'hA5);
      for (int i = 15; i >= 0; i--) exp_q.push_back(data[i*8 +: 8]);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!mon_ready && n < BOUND) begin tick(); n++; end
      if (!mon_ready) begin
         checks++; errors++;
         $display("FAIL %s: blk_ready never rose within %0d cycles", name, BOUND);
      end
   endtask

   task automatic wait_end(input string name, input int s0, input int t0);
      int n = 0;
      while (sent_cnt == s0 && terr_cnt == t0 && n < BOUND) begin tick(); n++; end
      if (sent_cnt == s0 && terr_cnt == t0) begin
         checks++; errors++;
         $display("FAIL %s: no blk_sent/timeout_err within %0d cycles", name, BOUND);
      end
   endtask

   // Offers one block and returns the cycle at whose end it is accepted.
   task automatic offer(input logic [127:0] data, input string name, output int acc);
      wait_ready(name);
      blk_data = data;
      blk_valid = 1'b1;
      acc = cyc;
      tick();
      blk_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({ifa.blk_ready, ifa.tx_drive, ifa.busy, ifa.blk_sent, ifa.timeout_err, ifa.tx_byte_in} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy%b drv%b busy%b sent%b terr%b byte%h required all 0",
                  ifa.blk_ready, ifa.tx_drive, ifa.busy, ifa.blk_sent, ifa.timeout_err, ifa.tx_byte_in);
      end
      reset_n = 1'b1;
      checks++;
      if (ifa.blk_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release: got %b required 0", ifa.blk_ready); end
      tick();
      checks++;
      if (ifa.blk_ready !== 1'b1 || ifb.blk_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release: got %b/%b required 1/1", ifa.blk_ready, ifb.blk_ready);
      end
   endtask

   task automatic run_one(input string name, input logic [127:0] data, input bit hdr, input int nbytes);
      int acc, s0, t0;
      s0 = sent_cnt; t0 = terr_cnt;
      drv_cnt = 0; first_drive_cyc = -1;
      push_block(data, hdr);
      offer(data, name, acc);
      blk_data = ~data;
      wait_end(name, s0, t0);
      checks++;
      if (first_drive_cyc !== acc + 1) begin errors++; $display("FAIL %s_first_drive: cycle %0d required %0d", name, first_drive_cyc, acc + 1); end
      checks++;
      if (drv_cnt !== nbytes) begin errors++; $display("FAIL %s_drive_count: got %0d required %0d", name, drv_cnt, nbytes); end
      checks++;
      if (sent_cnt - s0 !== 1 || terr_cnt !== t0) begin
         errors++;
         $display("FAIL %s_events: blk_sent %0d timeout_err %0d required 1 and 0", name, sent_cnt - s0, terr_cnt - t0);
      end
      checks++;
      if (last_sent_cyc !== last_done_cyc + 1) begin errors++; $display("FAIL %s_sent_latency: cycle %0d required %0d", name, last_sent_cyc, last_done_cyc + 1); end
      checks++;
      if (mon_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_in_finish: got %b required 0", name, mon_ready); end
      tick();
      checks++;
      if (mon_ready !== 1'b1 || mon_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_ready_after: ready %b busy %b required 1 0", name, mon_ready, mon_busy);
      end
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_leftover: %0d bytes not sent required 0", name, exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_header_block();
      sel = 1'b0;
      run_one("hdr_block", B1, 1'b1, 17);
   endtask

   task automatic test_no_header();
      sel = 1'b1;
      tick();
      run_one("nohdr_block", B1, 1'b0, 16);
      sel = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int acc, s0, t0;
      sel = 1'b0; s0 = sent_cnt; t0 = terr_cnt;
      drv_cnt = 0; mute_idx = 3;
      push_block(B2, 1'b1);
      offer(B2, "timeout", acc);
      wait_end("timeout", s0, t0);
      checks++;
      if (terr_cnt - t0 !== 1 || sent_cnt !== s0) begin
         errors++;
         $display("FAIL timeout_events: timeout_err %0d blk_sent %0d required 1 and 0", terr_cnt - t0, sent_cnt - s0);
      end
      checks++;
      if (last_terr_cyc !== last_drive_cyc + 64) begin
         errors++;
         $display("FAIL timeout_latency: %0d clks after tx_drive required 64", last_terr_cyc - last_drive_cyc);
      end
      checks++;
      if (drv_cnt !== 4) begin errors++; $display("FAIL timeout_drive_count: got %0d required 4", drv_cnt); end
      checks++;
      if (mon_ready !== 1'b1 || mon_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: ready %b busy %b required 1 0", mon_ready, mon_busy);
      end
      tick();
      checks++;
      if (mon_terr !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b required 0", mon_terr); end
      mute_idx = -1;
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int acc2, s0, t0, n, s1;
      sel = 1'b0; s0 = sent_cnt; t0 = terr_cnt; drv_cnt = 0;
      push_block(B1, 1'b1);
      push_block(B2, 1'b1);
      wait_ready("b2b");
      blk_data = B1;
      blk_valid = 1'b1;
      tick();
      blk_data = B2;
      n = 0;
      while (sent_cnt == s0 && n < BOUND) begin tick(); n++; end
      s1 = last_sent_cyc;
      n = 0;
      while (!mon_ready && n < BOUND) begin tick(); n++; end
      acc2 = cyc;
      tick();
      blk_valid = 1'b0;
      checks++;
      if (acc2 !== s1 + 1) begin errors++; $display("FAIL b2b_accept: cycle %0d required %0d", acc2, s1 + 1); end
      n = 0;
      while (sent_cnt < s0 + 2 && n < BOUND) begin tick(); n++; end
      checks++;
      if (sent_cnt - s0 !== 2 || terr_cnt !== t0) begin
         errors++;
         $display("FAIL b2b_events: blk_sent %0d timeout_err %0d required 2 and 0", sent_cnt - s0, terr_cnt - t0);
      end
      checks++;
      if (drv_cnt !== 34 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_bytes: drives %0d leftover %0d required 34 and 0", drv_cnt, exp_q.size());
      end
      exp_q.delete();
      tick();
   endtask

   task automatic test_reset_mid_block();
      int acc, s0, t0, n;
      sel = 1'b0; s0 = sent_cnt; t0 = terr_cnt; drv_cnt = 0;
      push_block(B2, 1'b1);
      offer(B2, "mid_reset", acc);
      n = 0;
      while (drv_cnt < 8 && n < BOUND) begin tick(); n++; end
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({ifa.blk_ready, ifa.tx_drive, ifa.busy, ifa.blk_sent, ifa.timeout_err, ifa.tx_byte_in} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: rdy%b drv%b busy%b sent%b terr%b byte%h required all 0",
                  ifa.blk_ready, ifa.tx_drive, ifa.busy, ifa.blk_sent, ifa.timeout_err, ifa.tx_byte_in);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (mon_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b required 1", mon_ready); end
      repeat (20) tick();
      exp_q.delete();
      checks++;
      if (sent_cnt !== s0 || terr_cnt !== t0 || mon_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_silent: blk_sent %0d timeout_err %0d busy %b required 0 0 0",
                  sent_cnt - s0, terr_cnt - t0, mon_busy);
      end
      run_one("post_reset", B1, 1'b1, 17);
   endtask

   task automatic test_spurious_done();
      int s0, t0, n;
      sel = 1'b0; s0 = sent_cnt; t0 = terr_cnt; drv_cnt = 0;
      stretch = 1'b1;
      wait_ready("spurious");
      inj_done = 1'b1;
      repeat (3) tick();
      checks++;
      if (mon_busy !== 1'b0 || mon_drive !== 1'b0) begin
         errors++;
         $display("FAIL spurious_idle: busy %b drive %b required 0 0", mon_busy, mon_drive);
      end
      push_block(B2, 1'b1);
      blk_data = B2;
      blk_valid = 1'b1;
      tick();
      blk_valid = 1'b0;
      tick();
      inj_done = 1'b0;
      n = 0;
      while (sent_cnt == s0 && terr_cnt == t0 && n < BOUND) begin tick(); n++; end
      stretch = 1'b0;
      checks++;
      if (sent_cnt - s0 !== 1 || terr_cnt !== t0) begin
         errors++;
         $display("FAIL spurious_events: blk_sent %0d timeout_err %0d required 1 and 0", sent_cnt - s0, terr_cnt - t0);
      end
      checks++;
      if (drv_cnt !== 17 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL spurious_bytes: drives %0d leftover %0d required 17 and 0", drv_cnt, exp_q.size());
      end
      exp_q.delete();
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_header_block();
      test_no_header();
      test_timeout();
      test_back_to_back();
      test_reset_mid_block();
      test_spurious_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
